// File: rtl/fu_issue_sched.sv
// In-order issue scheduler: buffers decode groups in a ring and
// issues them in program order to ALU0, ALU1, MDU and BRU slots.
module fu_issue_sched #(
  parameter int ISSUE_NUM = 4,
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ISSUE_NUM-1:0]                in_valid,
  input  logic [ISSUE_NUM-1:0][1:0]           in_class,
  input  logic [ISSUE_NUM-1:0][PAYLOAD_W-1:0] in_payload,
  output logic                                in_ready,
  input  logic                                flush,
  input  logic [ISSUE_NUM-1:0]                fu_busy,
  output logic [ISSUE_NUM-1:0]                slot_valid,
  output logic [ISSUE_NUM-1:0][PAYLOAD_W-1:0] slot_payload,
  output logic [$clog2(DEPTH):0]              occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ISSUE_C = CW'(ISSUE_NUM);

  localparam logic [1:0] CLS_MDU = 2'b01;
  localparam logic [1:0] CLS_BRU = 2'b10;

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;

  logic [DEPTH-1:0][1:0]           buf_cls;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] buf_pl;

  logic [ISSUE_NUM-1:0]                sel_valid;
  logic [ISSUE_NUM-1:0][PAYLOAD_W-1:0] sel_payload;
  logic [CW-1:0]                       n_issue;
  logic                                stop;
  logic [PW-1:0]                       rd_idx;
  logic [1:0]                          rd_cls;

  logic [ISSUE_NUM-1:0][PW-1:0] wr_idx;
  logic [PW-1:0]                wr_off;
  logic [CW-1:0]                in_cnt;
  logic [CW-1:0]                enq_cnt;
  logic                         do_enq;

  assign in_ready  = (DEPTH_C - count) >= ISSUE_C;
  assign occupancy = count;
  assign do_enq    = in_ready && (|in_valid) && !flush;
  assign enq_cnt   = do_enq ? in_cnt : '0;

  // Compact valid lanes: each lane lands after all older valid lanes.
  always_comb begin
    wr_idx = '0;
    wr_off = '0;
    in_cnt = '0;
    for (int l = 0; l < ISSUE_NUM; l++) begin
      wr_idx[l] = tail_ptr + wr_off;
      wr_off    = wr_off + PW'(in_valid[l]);
      in_cnt    = in_cnt + CW'(in_valid[l]);
    end
  end

  // Walk the oldest entries in order; first blocked entry ends the group.
  always_comb begin
    sel_valid   = '0;
    sel_payload = '0;
    n_issue     = '0;
    stop        = 1'b0;
    rd_idx      = '0;
    rd_cls      = '0;
    for (int i = 0; i < ISSUE_NUM; i++) begin
      rd_idx = head_ptr + PW'(i);
      rd_cls = buf_cls[rd_idx];
      if (!stop && (CW'(i) < count)) begin
        unique case (1'b1)
          (rd_cls == CLS_BRU): begin
            if (!fu_busy[3]) begin
              sel_valid[3]   = 1'b1;
              sel_payload[3] = buf_pl[rd_idx];
              n_issue        = n_issue + CW'(1);
            end
            stop = 1'b1;
          end
          (rd_cls == CLS_MDU): begin
            if (!sel_valid[2] && !fu_busy[2]) begin
              sel_valid[2]   = 1'b1;
              sel_payload[2] = buf_pl[rd_idx];
              n_issue        = n_issue + CW'(1);
            end else begin
              stop = 1'b1;
            end
          end
          default: begin
            if (!sel_valid[0] && !fu_busy[0]) begin
              sel_valid[0]   = 1'b1;
              sel_payload[0] = buf_pl[rd_idx];
              n_issue        = n_issue + CW'(1);
            end else if (!sel_valid[1] && !fu_busy[1]) begin
              sel_valid[1]   = 1'b1;
              sel_payload[1] = buf_pl[rd_idx];
              n_issue        = n_issue + CW'(1);
            end else begin
              stop = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Flush kills this cycle's issue outright.
  always_comb begin
    slot_valid   = flush ? '0 : sel_valid;
    slot_payload = flush ? '0 : sel_payload;
  end

  // Ring state: flush wins over enqueue and issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      buf_cls  <= '0;
      buf_pl   <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_enq) begin
        for (int l = 0; l < ISSUE_NUM; l++) begin
          if (in_valid[l]) begin
            buf_cls[wr_idx[l]] <= in_class[l];
            buf_pl[wr_idx[l]]  <= in_payload[l];
          end
        end
      end
      tail_ptr <= tail_ptr + PW'(enq_cnt);
      head_ptr <= head_ptr + PW'(n_issue);
      count    <= count + enq_cnt - n_issue;
    end
  end

endmodule
